// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, command words and layout helpers for the PE engine
//   pe_state_e      : host sequencer states
//   CMD_START/CLEAR : command words written to the BRAM command slot
//   half_words()    : matrix words in the BRAM image (N*N/2, two elements per word)
//   load_words()    : total words loaded by the host (matrix + vector)
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CMD,
        ST_WAIT,
        ST_CLR,
        ST_READ,
        ST_FIN
    } pe_state_e;

    localparam logic [31:0] CMD_START = 32'h0000_5555;
    localparam logic [31:0] CMD_CLEAR = 32'h0000_0000;

    function automatic int half_words(input int n);
        return (n * n) / 2;
    endfunction

    function automatic int load_words(input int n);
        return half_words(n) + (n / 2);
    endfunction

endpackage

// File: rtl/pe_host_seq_if.sv
// rtl/pe_host_seq_if.sv - input stream, result stream and BRAM port of the host sequencer
//   s_valid/s_ready/s_data : packed matrix/vector words into the sequencer
//   m_valid/m_ready/m_data : result words out of the sequencer
//   BRAM_*                 : shared BRAM port (byte addresses, one-cycle read latency)
//   master : sequencer side, slave : environment side
interface pe_host_seq_if;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;

    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;

    logic [31:0] BRAM_ADDR;
    logic        BRAM_EN;
    logic [3:0]  BRAM_WE;
    logic [31:0] BRAM_WRDATA;
    logic [31:0] BRAM_RDDATA;

    modport master (
        input  s_valid, s_data, m_ready, BRAM_RDDATA,
        output s_ready, m_valid, m_data, BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_WRDATA
    );

    modport slave (
        output s_valid, s_data, m_ready, BRAM_RDDATA,
        input  s_ready, m_valid, m_data, BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_WRDATA
    );

endinterface

// File: rtl/pe_res_fifo.sv
// rtl/pe_res_fifo.sv - 2-entry 32-bit result FIFO
//   aclk, aresetn         : clock, asynchronous active-low reset
//   push, push_data       : write side (push accepted when not full, or when popping)
//   pop, pop_data         : read side (pop_data is the head, valid while !empty)
//   full, empty, count    : occupancy status
module pe_res_fifo (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] pop_data,
    output logic        full,
    output logic        empty,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_host_seq.sv
// rtl/pe_host_seq.sv - host sequencer: load BRAM image, start PE, stream results back
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus           : input stream, result stream and BRAM port (pe_host_seq_if.master)
//   go            : one-cycle start pulse, honoured only in IDLE
//   pe_done       : one-cycle completion pulse from the PE controller, honoured only in WAIT
//   busy          : high in every state except IDLE
//   xfer_done     : one-cycle pulse after the last result handshake
module pe_host_seq
    import pe_pkg::*;
#(
    parameter int VECTOR_SIZE = 64,
    parameter int ADDR_W      = 13,
    parameter int CMD_ADDR    = 4095,
    parameter int RES_BASE    = 0
) (
    input  logic         aclk,
    input  logic         aresetn,
    pe_host_seq_if.master bus,
    input  logic         go,
    input  logic         pe_done,
    output logic         busy,
    output logic         xfer_done
);

    localparam int                CNT_W   = $clog2(VECTOR_SIZE) + 1;
    localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(load_words(VECTOR_SIZE) - 1);
    localparam logic [ADDR_W-1:0] CMD_WA  = ADDR_W'(CMD_ADDR);
    localparam logic [ADDR_W-1:0] RES_WA  = ADDR_W'(RES_BASE);
    localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(VECTOR_SIZE);

    pe_state_e         state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic              inflight;
    logic              s_ready_q;
    logic              busy_q;
    logic              xfer_q;

    logic              wr_hs;
    logic              rd_issue;
    logic              read_last;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [31:0]       fifo_data;
    logic [2:0]        pending;
    logic [2:0]        limit;

    logic [ADDR_W-1:0] word_addr;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [31:0]       bram_wrdata;

    assign wr_hs    = (state == ST_LOAD) && bus.s_valid && s_ready_q;
    assign fifo_pop = bus.m_ready && !fifo_empty;

    // A result leaving the FIFO this cycle frees its slot for a read issued now;
    // without that credit the FIFO could never sustain one result per cycle.
    assign pending  = {1'b0, fifo_count} + {2'b0, inflight};
    assign limit    = 3'd2 + {2'b0, fifo_pop};
    assign rd_issue = (state == ST_READ) && (rd_cnt != RD_LAST) &&
                      (!fifo_full || fifo_pop) && (pending < limit);

    // Leave READ on the same edge as the final handshake so xfer_done follows it directly.
    assign read_last = (rd_cnt == RD_LAST) && !inflight &&
                       (fifo_empty || ((fifo_count == 2'd1) && fifo_pop));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            inflight  <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            xfer_q    <= 1'b0;
        end else begin
            inflight <= rd_issue;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        wr_cnt    <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (wr_hs) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST_WR) begin
                            s_ready_q <= 1'b0;
                            state     <= ST_CMD;
                        end
                    end
                end
                ST_CMD:  state <= ST_WAIT;
                ST_WAIT: begin
                    if (pe_done) begin
                        state <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    rd_cnt <= '0;
                    state  <= ST_READ;
                end
                ST_READ: begin
                    if (rd_issue) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (read_last) begin
                        xfer_q <= 1'b1;
                        state  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    xfer_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // BRAM port is decoded from state so an asynchronous reset silences it at once.
    always_comb begin
        word_addr   = '0;
        bram_en     = 1'b0;
        bram_we     = 4'h0;
        bram_wrdata = '0;
        case (state)
            ST_LOAD: begin
                if (wr_hs) begin
                    word_addr   = wr_cnt;
                    bram_en     = 1'b1;
                    bram_we     = 4'hF;
                    bram_wrdata = bus.s_data;
                end
            end
            ST_CMD: begin
                word_addr   = CMD_WA;
                bram_en     = 1'b1;
                bram_we     = 4'hF;
                bram_wrdata = CMD_START;
            end
            ST_CLR: begin
                word_addr   = CMD_WA;
                bram_en     = 1'b1;
                bram_we     = 4'hF;
                bram_wrdata = CMD_CLEAR;
            end
            ST_READ: begin
                if (rd_issue) begin
                    word_addr = RES_WA + ADDR_W'(rd_cnt);
                    bram_en   = 1'b1;
                end
            end
            default: begin
                bram_en = 1'b0;
            end
        endcase
    end

    pe_res_fifo u_res_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (inflight),
        .push_data (bus.BRAM_RDDATA),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.s_ready     = s_ready_q;
    assign bus.m_valid     = !fifo_empty;
    assign bus.m_data      = fifo_data;
    assign bus.BRAM_ADDR   = {{(30 - ADDR_W){1'b0}}, word_addr, 2'b00};
    assign bus.BRAM_EN     = bram_en;
    assign bus.BRAM_WE     = bram_we;
    assign bus.BRAM_WRDATA = bram_wrdata;
    assign busy            = busy_q;
    assign xfer_done       = xfer_q;

endmodule

// File: tb/tb_pe_host_seq.sv
// tb/tb_pe_host_seq.sv - self-checking bench for pe_host_seq with N=4
module tb_pe_host_seq;

    localparam int          N        = 4;
    localparam int          LW       = 10;
    localparam logic [31:0] CMD_BYTE = 32'h0000_3FFC;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic go      = 1'b0;
    logic pe_done = 1'b0;
    logic busy;
    logic xfer_done;

    pe_host_seq_if bus ();

    always #5 aclk = ~aclk;

    pe_host_seq #(
        .VECTOR_SIZE (N),
        .ADDR_W      (13),
        .CMD_ADDR    (4095),
        .RES_BASE    (0)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .bus       (bus),
        .go        (go),
        .pe_done   (pe_done),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    // BRAM model: one-cycle read latency; preload stands in for the PE writing results
    logic [31:0]       mem [0:8191];
    logic              preload_req  = 1'b0;
    logic [3:0][31:0]  preload_vals = '0;

    always @(posedge aclk) begin
        if (preload_req) begin
            for (int i = 0; i < 4; i++) mem[i] <= preload_vals[i];
        end
        if (bus.BRAM_EN) begin
            if (bus.BRAM_WE == 4'hF) mem[bus.BRAM_ADDR[14:2]] <= bus.BRAM_WRDATA;
            else                     bus.BRAM_RDDATA <= mem[bus.BRAM_ADDR[14:2]];
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          c;
    } wr_t;

    wr_t         wr_log[$];
    logic [31:0] res_log[$];
    int          res_cyc[$];
    int          rd_seen, xfer_cnt, xfer_cyc, first_mv, os, max_os;
    int          stable_err, bad_we, bad_ld;
    logic        prev_stall;
    logic [31:0] prev_data;

    task automatic clear_logs();
        wr_log.delete();
        res_log.delete();
        res_cyc.delete();
        rd_seen    = 0;
        xfer_cnt   = 0;
        xfer_cyc   = -1;
        first_mv   = -1;
        max_os     = 0;
        stable_err = 0;
        bad_we     = 0;
        bad_ld     = 0;
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            os         = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.BRAM_EN && bus.BRAM_WE == 4'hF) begin
                wr_log.push_back('{bus.BRAM_ADDR, bus.BRAM_WRDATA, cyc});
                if (bus.BRAM_ADDR != CMD_BYTE && !bus.s_valid) bad_ld++;
            end
            if (bus.BRAM_WE != 4'h0 && bus.BRAM_WE != 4'hF) bad_we++;
            if (!bus.BRAM_EN && bus.BRAM_WE != 4'h0) bad_we++;
            if (bus.BRAM_EN && bus.BRAM_WE == 4'h0) rd_seen++;
            if (bus.m_valid && first_mv < 0) first_mv = cyc;
            if (prev_stall && bus.m_data != prev_data) stable_err++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            if (bus.m_valid && bus.m_ready) begin
                res_log.push_back(bus.m_data);
                res_cyc.push_back(cyc);
            end
            if (xfer_done) begin
                xfer_cnt++;
                xfer_cyc = cyc;
            end
            os = os + ((bus.BRAM_EN && bus.BRAM_WE == 4'h0) ? 1 : 0)
                    - ((bus.m_valid && bus.m_ready) ? 1 : 0);
            if (os > max_os) max_os = os;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_s_ready"},   {31'b0, bus.s_ready}, 32'h0);
        chk({tag, "_m_valid"},   {31'b0, bus.m_valid}, 32'h0);
        chk({tag, "_m_data"},    bus.m_data,           32'h0);
        chk({tag, "_busy"},      {31'b0, busy},        32'h0);
        chk({tag, "_xfer_done"}, {31'b0, xfer_done},   32'h0);
        chk({tag, "_bram_en"},   {31'b0, bus.BRAM_EN}, 32'h0);
        chk({tag, "_bram_we"},   {28'b0, bus.BRAM_WE}, 32'h0);
        chk({tag, "_bram_addr"}, bus.BRAM_ADDR,        32'h0);
        chk({tag, "_bram_wr"},   bus.BRAM_WRDATA,      32'h0);
    endtask

    task automatic start_go(output int gc);
        @(posedge aclk);
        #1;
        go = 1'b1;
        gc = cyc;
        @(posedge aclk);
        #1;
        go = 1'b0;
    endtask

    typedef struct {
        logic             throttle;
        int               stall;
        logic             spurious;
        logic [31:0]      dseed;
        int               exp_cmd_lat;
        logic [3:0][31:0] res;
    } vec_t;

    task automatic run_txn(input vec_t v, input string tag);
        int          gc, sent, cmd_c, pd_c, g;
        logic        tog, found;
        logic [31:0] ea, ed;
        clear_logs();
        bus.m_ready = (v.stall == 0);
        start_go(gc);
        sent = 0;
        g    = 0;
        tog  = 1'b1;
        while (sent < LW && g < 100) begin
            bus.s_valid = v.throttle ? tog : 1'b1;
            tog         = ~tog;
            bus.s_data  = v.dseed + 32'(sent);
            go          = v.spurious && (sent == 3);
            pe_done     = v.spurious && (sent == 3);
            @(negedge aclk);
            if (bus.s_valid && bus.s_ready) sent++;
            @(posedge aclk);
            #1;
            g++;
        end
        bus.s_valid = 1'b0;
        go          = 1'b0;
        pe_done     = 1'b0;
        chk({tag, "_load_count"}, sent, LW);

        found = 1'b0;
        g     = 0;
        cmd_c = 0;
        while (!found && g < 50) begin
            @(negedge aclk);
            if (bus.BRAM_EN && bus.BRAM_WE == 4'hF && bus.BRAM_ADDR == CMD_BYTE &&
                bus.BRAM_WRDATA == 32'h5555) begin
                found = 1'b1;
                cmd_c = cyc;
            end
            g++;
        end
        chk({tag, "_cmd_seen"}, {31'b0, found}, 32'h1);
        chk({tag, "_cmd_latency"}, cmd_c - gc, v.exp_cmd_lat);

        for (int i = 0; i < 20; i++) begin
            @(posedge aclk);
            #1;
            go = v.spurious && (i == 10);
        end
        go           = 1'b0;
        preload_vals = v.res;
        preload_req  = 1'b1;
        pe_done      = 1'b1;
        pd_c         = cyc;
        @(posedge aclk);
        #1;
        pe_done     = 1'b0;
        preload_req = 1'b0;

        if (v.stall > 0) begin
            found = 1'b0;
            g     = 0;
            while (!found && g < 20) begin
                @(negedge aclk);
                if (bus.m_valid) found = 1'b1;
                g++;
            end
            chk({tag, "_mvalid_seen"}, {31'b0, found}, 32'h1);
            repeat (v.stall) @(posedge aclk);
            #1;
            bus.m_ready = 1'b1;
        end

        found = 1'b0;
        g     = 0;
        while (!found && g < 100) begin
            @(negedge aclk);
            if (xfer_done) found = 1'b1;
            g++;
        end
        chk({tag, "_xfer_seen"}, {31'b0, found}, 32'h1);
        repeat (3) @(posedge aclk);
        #1;

        chk({tag, "_wr_total"}, wr_log.size(), LW + 2);
        for (int i = 0; i < LW + 2 && i < wr_log.size(); i++) begin
            if (i < LW) begin
                ea = 32'(4 * i);
                ed = v.dseed + 32'(i);
            end else begin
                ea = CMD_BYTE;
                ed = (i == LW) ? 32'h0000_5555 : 32'h0;
            end
            chk($sformatf("%s_wr_addr[%0d]", tag, i), wr_log[i].addr, ea);
            chk($sformatf("%s_wr_data[%0d]", tag, i), wr_log[i].data, ed);
        end
        if (wr_log.size() == LW + 2) chk({tag, "_clr_cycle"}, wr_log[LW + 1].c, pd_c + 1);
        chk({tag, "_first_mvalid"}, first_mv, pd_c + 4);
        chk({tag, "_res_count"}, res_log.size(), N);
        for (int i = 0; i < N && i < res_log.size(); i++) begin
            chk($sformatf("%s_res[%0d]", tag, i), res_log[i], v.res[i]);
        end
        if (v.stall == 0 && res_cyc.size() == N)
            chk({tag, "_res_rate"}, res_cyc[N - 1] - res_cyc[0], N - 1);
        chk({tag, "_xfer_count"}, xfer_cnt, 1);
        if (res_cyc.size() == N) chk({tag, "_xfer_cycle"}, xfer_cyc, res_cyc[N - 1] + 1);
        chk({tag, "_rd_count"}, rd_seen, N);
        chk({tag, "_max_outstanding_ok"}, {31'b0, max_os <= 2}, 32'h1);
        chk({tag, "_m_data_stable"}, stable_err, 0);
        chk({tag, "_we_legal"}, bad_we, 0);
        chk({tag, "_no_idle_write"}, bad_ld, 0);
        chk({tag, "_busy_end"}, {31'b0, busy}, 32'h0);
    endtask

    vec_t vecs [4];

    initial begin
        int gc;
        vecs[0] = '{1'b0, 0, 1'b0, 32'h1000_0000, 11,
                    {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}};
        vecs[1] = '{1'b1, 0, 1'b0, 32'h2000_0000, 20,
                    {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}};
        vecs[2] = '{1'b0, 5, 1'b0, 32'h3000_0100, 11,
                    {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
        vecs[3] = '{1'b1, 0, 1'b1, 32'h4000_0000, 20,
                    {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        clear_logs();

        repeat (3) @(posedge aclk);
        #1;
        chk_idle_outputs("reset");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk({"idle_s_ready"}, {31'b0, bus.s_ready}, 32'h0);

        for (int v = 0; v < 4; v++) begin
            run_txn(vecs[v], $sformatf("v%0d", v));
        end

        // Asynchronous reset in the middle of LOAD, with wr_cnt at 5
        clear_logs();
        start_go(gc);
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h5000_0000 + 32'(i);
            @(posedge aclk);
            #1;
        end
        bus.s_data = 32'h5000_0005;
        aresetn    = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        chk("midrst_writes", wr_log.size(), 5);
        bus.s_valid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        run_txn(vecs[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/pe_host_seq.md
# pe_host_seq

Host-side sequencer for the PE matrix-vector engine, on the other side of the shared BRAM. It accepts pre-packed matrix/vector words on an input stream and writes them into the BRAM image that the PE controller reads. It then writes the 0x5555 start command and waits for the controller's done pulse. Finally it reads the N result words back and emits them on an output stream with backpressure.

## Interface
- VECTOR_SIZE, 64, matrix dimension N (power of two, ≥4)
- ADDR_W, 13, word-address width
- CMD_ADDR, 4095, word address of the command word
- RES_BASE, 0, word address of result word 0
- aclk  in  1  sole clock; BRAM runs on the same clock
- aresetn  in  1  asynchronous, active-low reset
- go  in  1  one-cycle pulse; starts a transaction (ignored unless IDLE)
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid&&s_ready
- s_data  in  32  packed word: [31:16] element k, [15:0] element k+HALF
- pe_done  in  1  one-cycle done pulse from the PE controller
- m_valid  out  1  result word valid
- m_ready  in  1  downstream accepts result
- m_data  out  32  result word
- busy  out  1  high in every state except IDLE
- xfer_done  out  1  one-cycle pulse after the last result handshake
- BRAM_ADDR  out  32  byte address = word address << 2
- BRAM_EN  out  1  BRAM access enable
- BRAM_WE  out  4  byte write enables (0xF or 0x0 only)
- BRAM_WRDATA  out  32  write data
- BRAM_RDDATA  in  32  read data, valid one cycle after the address

## Operation
- Derived constants: HALF = N*N/2 and LOAD_WORDS = HALF + N/2 (2080 for N=64).
- Word layout written by this block: words 0..HALF-1 hold the matrix; words HALF..LOAD_WORDS-1 hold the vector.
- FSM states: IDLE, LOAD, CMD, WAIT, CLR, READ, FIN.
- IDLE: s_ready=0. On go, clear wr_cnt and move to LOAD.
- LOAD: s_ready=1. Each input handshake writes s_data to word wr_cnt with WE=0xF, EN=1, then increments wr_cnt. When the handshake with wr_cnt==LOAD_WORDS-1 completes, move to CMD. Cycles without s_valid produce no BRAM access.
- CMD: write 0x00005555 to CMD_ADDR for one cycle, then move to WAIT.
- WAIT: BRAM idle. On pe_done, move to CLR. A pe_done in any other state is ignored.
- CLR: write 0x00000000 to CMD_ADDR so the controller cannot restart. Clear rd_cnt and move to READ.
- READ: read words RES_BASE+rd_cnt for rd_cnt = 0..N-1 in order, and push the returned data into a 2-entry output FIFO.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2.
  - After N reads are issued and the FIFO has drained, move to FIN.
- FIN: pulse xfer_done for one cycle, then return to IDLE.
- go while busy is ignored.

## Timing
- Reset values: state=IDLE, s_ready=0, m_valid=0, m_data=0, busy=0, xfer_done=0, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_WRDATA=0.
- LOAD throughput is 1 word/cycle. BRAM_ADDR, BRAM_WE and BRAM_WRDATA are combinational from the handshake in the same cycle.
- Minimum go-to-CMD latency is LOAD_WORDS+1 cycles.
- Read latency is fixed at 1 cycle: data for an address issued in cycle t is captured into the FIFO at the edge ending cycle t+1.
- With m_ready held high, throughput is 1 result/cycle. The first m_valid occurs 2 cycles after READ is entered.
- m_data is stable while m_valid && !m_ready. A FIFO push and pop in the same cycle leaves occupancy unchanged.
- xfer_done is asserted the cycle after the N-th m_valid&&m_ready.
- Asynchronous reset mid-transaction returns to IDLE immediately, with no further BRAM write. The FIFO and all counters are cleared.
- Counter widths: wr_cnt is ADDR_W bits, rd_cnt is log2(N)+1 bits, and there is no wrap-around.

## Structure
- Shared package pe_pkg holds:
  - the state enum
  - CMD_START = 32'h5555
  - CMD_CLEAR = 32'h0
  - the HALF and LOAD_WORDS functions of VECTOR_SIZE, also used by the PE controller
- Sub-module: pe_res_fifo, a 2-entry 32-bit FIFO with push/pop, full/empty and a count output.

## Test plan
- N=4 (LOAD_WORDS=10), s_valid always high, go pulse:
  - 10 consecutive writes to byte addresses 0x0..0x24 with data matching the input.
  - Then 0x5555 is written to CMD_ADDR<<2.
- Throttled LOAD, s_valid toggling 1/0: exactly 10 writes, no duplicates, and no write on idle cycles.
- Model the BRAM response: pe_done 20 cycles after CMD, results preloaded as 0xA0..0xA3:
  - the CLR write of 0 to CMD_ADDR happens first;
  - m_data is then 0xA0, 0xA1, 0xA2, 0xA3;
  - xfer_done pulses once.
- m_ready low for 5 cycles during READ: at most 2 reads outstanding, m_data held stable, no result lost or reordered.
- Spurious pe_done in LOAD, and go while busy: both are ignored and the transaction completes normally.
- aresetn low mid-LOAD at wr_cnt=5: all outputs return to reset values immediately; a new go restarts from word 0.
